// File: rtl/svm_job_sched.sv
// -----------------------------------------------------------------------------
// svm_job_sched
// Round-robin job scheduler that shares one svm_core between N_REQ requesters.
// A requester is granted the core input stream for a whole job of FEAT_WORDS
// words. Its ID is pushed into an in-order tag FIFO. Each single-word core
// result is routed back to the requester whose ID is at the FIFO head.
//
// Ports
//   ap_clk, ap_rst                 clock, asynchronous active-high reset
//   req_TDATA/TVALID/TREADY        N_REQ host request streams (32 bits each)
//   rsp_TDATA/TVALID/TREADY        shared result word, one-hot valid per requester
//   core_in_TDATA/TVALID/TREADY    job stream toward svm_core
//   core_out_TDATA/TVALID/TREADY   result stream from svm_core
//   busy                           streaming a job or results still outstanding
//   jobs_done                      count of delivered results (wraps)
//   err_orphan                     sticky: a core result arrived with no owner
// -----------------------------------------------------------------------------
module svm_job_sched #(
  parameter int N_REQ           = 4,
  parameter int FEAT_WORDS      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [N_REQ*32-1:0]  req_TDATA,
  input  logic [N_REQ-1:0]     req_TVALID,
  output logic [N_REQ-1:0]     req_TREADY,
  output logic [31:0]          rsp_TDATA,
  output logic [N_REQ-1:0]     rsp_TVALID,
  input  logic [N_REQ-1:0]     rsp_TREADY,
  output logic [31:0]          core_in_TDATA,
  output logic                 core_in_TVALID,
  input  logic                 core_in_TREADY,
  input  logic [31:0]          core_out_TDATA,
  input  logic                 core_out_TVALID,
  output logic                 core_out_TREADY,
  output logic                 busy,
  output logic [31:0]          jobs_done,
  output logic                 err_orphan
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W = (FEAT_WORDS > 1) ? $clog2(FEAT_WORDS) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [ID_W-1:0]    r_tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_jobs_done;
  logic               r_err_orphan;

  logic               w_any;
  logic [ID_W-1:0]    w_pick;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_orphan;
  logic               w_beat;
  logic [ID_W-1:0]    w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_head  = r_tag_mem[r_rd_ptr];
  assign w_push  = (r_state == S_IDLE) && !w_full && w_any;
  assign w_beat  = core_in_TVALID && core_in_TREADY;

  // Round-robin pick: scan offsets from high to low so the requester closest
  // to r_rr_ptr is written last and wins.
  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin : rr_search
    logic [ID_W:0] sum;
    w_any  = 1'b0;
    w_pick = '0;
    sum    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N_REQ)) sum = sum - (ID_W + 1)'(N_REQ);
      if (req_TVALID[sum[ID_W-1:0]]) begin
        w_any  = 1'b1;
        w_pick = sum[ID_W-1:0];
      end
    end
  end

  // Zero-latency pass-through of the granted request stream while streaming.
  always_comb begin
    core_in_TDATA  = '0;
    core_in_TVALID = 1'b0;
    req_TREADY     = '0;
    if (r_state == S_STREAM) begin
      core_in_TDATA       = req_TDATA[{r_grant, 5'b0} +: 32];
      core_in_TVALID      = req_TVALID[r_grant];
      req_TREADY[r_grant] = core_in_TREADY;
    end
  end

  // Result routing: the FIFO head owns the next core result. With no owner the
  // word is swallowed so the core cannot stall, and the error is flagged.
  always_comb begin
    rsp_TDATA       = '0;
    rsp_TVALID      = '0;
    core_out_TREADY = 1'b0;
    w_pop           = 1'b0;
    w_orphan        = 1'b0;
    if (!w_empty) begin
      rsp_TVALID[w_head] = core_out_TVALID;
      core_out_TREADY    = rsp_TREADY[w_head];
      w_pop              = core_out_TVALID && rsp_TREADY[w_head];
      if (core_out_TVALID) rsp_TDATA = core_out_TDATA;
    end else if (core_out_TVALID) begin
      core_out_TREADY = 1'b1;
      w_orphan        = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            if (r_beat_cnt == BEAT_W'(FEAT_WORDS - 1)) begin
              r_rr_ptr <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the tag storage has no reset; the count and pointers define which
  // entries are valid, so clearing the array would add nothing.
  always_ff @(posedge ap_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_pick;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_jobs_done  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_jobs_done <= r_jobs_done + 32'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

  assign busy       = (r_state == S_STREAM) || !w_empty;
  assign jobs_done  = r_jobs_done;
  assign err_orphan = r_err_orphan;

endmodule

// File: tb/tb_svm_job_sched.sv
// -----------------------------------------------------------------------------
// tb_svm_job_sched
// Directed bench for svm_job_sched with N_REQ=4, FEAT_WORDS=4,
// MAX_OUTSTANDING=2. Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_svm_job_sched;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [127:0] req_TDATA;
  logic [3:0]   req_TVALID;
  logic [3:0]   req_TREADY;
  logic [31:0]  rsp_TDATA;
  logic [3:0]   rsp_TVALID;
  logic [3:0]   rsp_TREADY;
  logic [31:0]  core_in_TDATA;
  logic         core_in_TVALID;
  logic         core_in_TREADY;
  logic [31:0]  core_out_TDATA;
  logic         core_out_TVALID;
  logic         core_out_TREADY;
  logic         busy;
  logic [31:0]  jobs_done;
  logic         err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  svm_job_sched #(.N_REQ(4), .FEAT_WORDS(4), .MAX_OUTSTANDING(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_TDATA(req_TDATA), .req_TVALID(req_TVALID), .req_TREADY(req_TREADY),
    .rsp_TDATA(rsp_TDATA), .rsp_TVALID(rsp_TVALID), .rsp_TREADY(rsp_TREADY),
    .core_in_TDATA(core_in_TDATA), .core_in_TVALID(core_in_TVALID),
    .core_in_TREADY(core_in_TREADY),
    .core_out_TDATA(core_out_TDATA), .core_out_TVALID(core_out_TVALID),
    .core_out_TREADY(core_out_TREADY),
    .busy(busy), .jobs_done(jobs_done), .err_orphan(err_orphan)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic apply_reset();
    ap_rst          = 1'b1;
    req_TDATA       = '0;
    req_TVALID      = '0;
    rsp_TREADY      = 4'b1111;
    core_in_TREADY  = 1'b1;
    core_out_TDATA  = '0;
    core_out_TVALID = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
  endtask

  // Streams one 4-word job for requester id (words base, base+1, ...) with
  // core_in_TREADY held high. Returns 1 unit after the edge of the last beat.
  task automatic run_job(input int id, input logic [31:0] base);
    int w = 0;
    req_TVALID                 = 4'(1 << id);
    req_TDATA[id*32 +: 32]     = base;
    core_in_TREADY             = 1'b1;
    for (int c = 0; c < 20 && w < 4; c++) begin
      @(negedge ap_clk);
      if (core_in_TVALID && core_in_TREADY) begin
        n_cmp++;
        if (core_in_TDATA !== base + 32'(w)) begin
          n_bad++;
          $display("FAIL job%0d_word%0d: got %h expected %h", id, w, core_in_TDATA, base + 32'(w));
        end
        w++;
      end
      tick();
      req_TDATA[id*32 +: 32] = base + 32'(w);
    end
    req_TVALID = '0;
    n_cmp++;
    if (w != 4) begin
      n_bad++;
      $display("FAIL job%0d_timeout: got %0d beats expected 4", id, w);
    end
  endtask

  task automatic test_reset();
    ap_rst          = 1'b1;
    req_TDATA       = '0;
    req_TVALID      = '0;
    rsp_TREADY      = '0;
    core_in_TREADY  = 1'b0;
    core_out_TDATA  = '0;
    core_out_TVALID = 1'b0;
    tick();
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL rst_req_tready: got %b expected 0000", req_TREADY); end
    n_cmp++; if (rsp_TVALID !== 4'b0) begin n_bad++; $display("FAIL rst_rsp_tvalid: got %b expected 0000", rsp_TVALID); end
    n_cmp++; if (rsp_TDATA !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_tdata: got %h expected 0", rsp_TDATA); end
    n_cmp++; if ({core_in_TVALID, core_out_TREADY} !== 2'b00) begin n_bad++; $display("FAIL rst_core_hs: got %b expected 00", {core_in_TVALID, core_out_TREADY}); end
    n_cmp++; if (core_in_TDATA !== 32'h0) begin n_bad++; $display("FAIL rst_core_tdata: got %h expected 0", core_in_TDATA); end
    n_cmp++; if ({busy, err_orphan} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b expected 00", {busy, err_orphan}); end
    n_cmp++; if (jobs_done !== 32'd0) begin n_bad++; $display("FAIL rst_jobs_done: got %0d expected 0", jobs_done); end
    ap_rst = 1'b0;
  endtask

  task automatic test_single_job();
    apply_reset();
    req_TVALID        = 4'b0010;
    req_TDATA[63:32]  = 32'd1;
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL single_idle_tready: got %b expected 0000", req_TREADY); end
    for (int w = 1; w <= 4; w++) begin
      tick();
      req_TDATA[63:32] = 32'(w);
      @(negedge ap_clk);
      n_cmp++; if (req_TREADY !== 4'b0010) begin n_bad++; $display("FAIL single_tready_w%0d: got %b expected 0010", w, req_TREADY); end
      n_cmp++; if (!core_in_TVALID || core_in_TDATA !== 32'(w)) begin n_bad++; $display("FAIL single_core_word%0d: got %h/%b expected %h/1", w, core_in_TDATA, core_in_TVALID, w); end
    end
    tick();
    req_TVALID = '0;
    @(negedge ap_clk);
    n_cmp++; if ({core_in_TVALID, busy} !== 2'b01) begin n_bad++; $display("FAIL single_after_job: got valid/busy %b expected 01", {core_in_TVALID, busy}); end
    tick();
    core_out_TDATA  = 32'hA5;
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0010) begin n_bad++; $display("FAIL single_rsp_tvalid: got %b expected 0010", rsp_TVALID); end
    n_cmp++; if (rsp_TDATA !== 32'hA5) begin n_bad++; $display("FAIL single_rsp_tdata: got %h expected a5", rsp_TDATA); end
    n_cmp++; if (core_out_TREADY !== 1'b1) begin n_bad++; $display("FAIL single_core_out_tready: got %b expected 1", core_out_TREADY); end
    tick();
    core_out_TVALID = 1'b0;
    @(negedge ap_clk);
    n_cmp++; if (jobs_done !== 32'd1) begin n_bad++; $display("FAIL single_jobs_done: got %0d expected 1", jobs_done); end
    n_cmp++; if ({busy, rsp_TVALID} !== 5'b0) begin n_bad++; $display("FAIL single_idle_after_rsp: got %b expected 00000", {busy, rsp_TVALID}); end
    n_cmp++; if (rsp_TDATA !== 32'h0) begin n_bad++; $display("FAIL single_rsp_tdata_idle: got %h expected 0", rsp_TDATA); end
  endtask

  // All four requesters always valid; each result is returned in the IDLE
  // bubble after its job, so that cycle both pushes and pops the tag FIFO.
  task automatic test_round_robin();
    int   exp_g [6] = '{0, 1, 2, 3, 0, 1};
    int   job = 0, beats = 0, res_idx = 0;
    logic result_due = 1'b0;
    apply_reset();
    req_TVALID = 4'b1111;
    for (int cyc = 0; cyc < 80 && job < 5; cyc++) begin
      core_out_TVALID = result_due;
      core_out_TDATA  = 32'h100 + 32'(res_idx);
      @(negedge ap_clk);
      n_cmp++;
      if (req_TREADY !== 4'b0 && req_TREADY !== 4'(1 << exp_g[job])) begin
        n_bad++; $display("FAIL rr_grant_job%0d: got %b expected %b or 0000", job, req_TREADY, 4'(1 << exp_g[job]));
      end
      if (core_out_TVALID) begin
        n_cmp++;
        if (rsp_TVALID !== 4'(1 << exp_g[res_idx])) begin
          n_bad++; $display("FAIL rr_rsp%0d: got %b expected %b", res_idx, rsp_TVALID, 4'(1 << exp_g[res_idx]));
        end
        res_idx++;
        result_due = 1'b0;
      end
      if (core_in_TVALID && core_in_TREADY) begin
        beats++;
        if (beats == 4) begin beats = 0; job++; result_due = 1'b1; end
      end
      tick();
    end
    n_cmp++; if (job != 5) begin n_bad++; $display("FAIL rr_timeout: got %0d jobs expected 5", job); end
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0001) begin n_bad++; $display("FAIL rr_rsp4: got %b expected 0001", rsp_TVALID); end
    tick();
    core_out_TVALID = 1'b0;
    req_TVALID      = '0;
    @(negedge ap_clk);
    n_cmp++; if (jobs_done !== 32'd5) begin n_bad++; $display("FAIL rr_jobs_done: got %0d expected 5", jobs_done); end
  endtask

  task automatic test_fifo_full();
    int beats = 0;
    apply_reset();
    req_TVALID = 4'b0101;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge ap_clk);
      if (core_in_TVALID && core_in_TREADY) beats++;
      tick();
    end
    @(negedge ap_clk);
    n_cmp++; if (beats != 8) begin n_bad++; $display("FAIL full_beats: got %0d expected 8", beats); end
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL full_no_grant: got %b expected 0000", req_TREADY); end
    n_cmp++; if ({core_in_TVALID, busy} !== 2'b01) begin n_bad++; $display("FAIL full_state: got valid/busy %b expected 01", {core_in_TVALID, busy}); end
    tick();
    core_out_TDATA  = 32'h33;
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0001 || rsp_TDATA !== 32'h33) begin n_bad++; $display("FAIL full_pop: got %b/%h expected 0001/33", rsp_TVALID, rsp_TDATA); end
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL full_pop_cycle_grant: got %b expected 0000", req_TREADY); end
    tick();
    core_out_TVALID = 1'b0;
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL full_decide_cycle: got %b expected 0000", req_TREADY); end
    tick();
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0001) begin n_bad++; $display("FAIL full_third_grant: got %b expected 0001", req_TREADY); end
  endtask

  // Ready toggles 1010.. and requester 3 gaps its valid; beats land on
  // cycles 4, 8, 12 and 16.
  task automatic test_gapped();
    logic [7:0] vpat = 8'b1011_1011;
    int w = 0, cyc = 0;
    apply_reset();
    for (cyc = 0; cyc < 40 && w < 4; cyc++) begin
      core_in_TREADY      = (cyc % 2 == 0);
      req_TVALID[3]       = vpat[cyc % 8];
      req_TDATA[127:96]   = vpat[cyc % 8] ? 32'h40 + 32'(w) : 32'hBAD;
      @(negedge ap_clk);
      n_cmp++;
      if (req_TREADY !== ((cyc == 0) ? 4'b0 : {core_in_TREADY, 3'b000})) begin
        n_bad++; $display("FAIL gap_tready_cyc%0d: got %b expected %b", cyc, req_TREADY, (cyc == 0) ? 4'b0 : {core_in_TREADY, 3'b000});
      end
      if (core_in_TVALID && core_in_TREADY) begin
        n_cmp++;
        if (core_in_TDATA !== 32'h40 + 32'(w)) begin n_bad++; $display("FAIL gap_word%0d: got %h expected %h", w, core_in_TDATA, 32'h40 + 32'(w)); end
        w++;
      end
      if (w < 4) tick();
    end
    n_cmp++; if (w != 4 || cyc != 17) begin n_bad++; $display("FAIL gap_done: got %0d beats by cycle %0d expected 4 by 17", w, cyc); end
    tick();
    req_TVALID     = '0;
    core_in_TREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      n_cmp++; if ({core_in_TVALID, req_TREADY} !== 5'b0) begin n_bad++; $display("FAIL gap_extra_beat%0d: got %b expected 00000", c, {core_in_TVALID, req_TREADY}); end
      tick();
    end
  endtask

  task automatic test_orphan_and_reset();
    apply_reset();
    core_out_TDATA  = 32'h77;
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if ({core_out_TREADY, rsp_TVALID} !== 5'b10000 || rsp_TDATA !== 32'h0) begin n_bad++; $display("FAIL orphan_accept: got %b/%h expected 10000/0", {core_out_TREADY, rsp_TVALID}, rsp_TDATA); end
    tick();
    core_out_TVALID = 1'b0;
    repeat (3) tick();
    @(negedge ap_clk);
    n_cmp++; if (err_orphan !== 1'b1 || jobs_done !== 32'd0) begin n_bad++; $display("FAIL orphan_sticky: got %b/%0d expected 1/0", err_orphan, jobs_done); end
    tick();
    run_job(1, 32'h10);
    req_TVALID        = 4'b0100;
    req_TDATA[95:64]  = 32'h20;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0100) begin n_bad++; $display("FAIL rst_mid_grant: got %b expected 0100", req_TREADY); end
    ap_rst = 1'b1;
    #1;
    n_cmp++; if ({req_TREADY, rsp_TVALID, core_in_TVALID, core_out_TREADY} !== 10'b0) begin n_bad++; $display("FAIL rst_mid_hs: got %b expected all 0", {req_TREADY, rsp_TVALID, core_in_TVALID, core_out_TREADY}); end
    n_cmp++; if ({busy, err_orphan} !== 2'b00 || jobs_done !== 32'd0 || core_in_TDATA !== 32'h0) begin n_bad++; $display("FAIL rst_mid_state: got busy/err %b jobs %0d data %h expected 00/0/0", {busy, err_orphan}, jobs_done, core_in_TDATA); end
    tick();
    ap_rst     = 1'b0;
    req_TVALID = 4'b0101;
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL rst_mid_idle: got %b expected 0000", req_TREADY); end
    tick();
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_restart: got %b expected 0001", req_TREADY); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    run_job(1, 32'h100);
    req_TVALID        = 4'b0100;
    req_TDATA[95:64]  = 32'h200;
    core_out_TDATA    = 32'hB1;
    core_out_TVALID   = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0010 || rsp_TDATA !== 32'hB1) begin n_bad++; $display("FAIL pp_old_head: got %b/%h expected 0010/b1", rsp_TVALID, rsp_TDATA); end
    tick();
    core_out_TVALID = 1'b0;
    run_job(2, 32'h200);
    run_job(3, 32'h300);
    req_TVALID       = 4'b0001;
    req_TDATA[31:0]  = 32'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      n_cmp++; if (req_TREADY !== 4'b0) begin n_bad++; $display("FAIL pp_full_hold%0d: got %b expected 0000", c, req_TREADY); end
      tick();
    end
    core_out_TDATA  = 32'hB2;
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0100 || rsp_TDATA !== 32'hB2) begin n_bad++; $display("FAIL pp_rsp_b: got %b/%h expected 0100/b2", rsp_TVALID, rsp_TDATA); end
    tick();
    core_out_TDATA = 32'hB3;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b1000 || rsp_TDATA !== 32'hB3) begin n_bad++; $display("FAIL pp_rsp_c: got %b/%h expected 1000/b3", rsp_TVALID, rsp_TDATA); end
    tick();
    core_out_TVALID = 1'b0;
    @(negedge ap_clk);
    n_cmp++; if (req_TREADY !== 4'b0001 || busy !== 1'b1) begin n_bad++; $display("FAIL pp_grant_d: got %b/%b expected 0001/1", req_TREADY, busy); end
    n_cmp++; if (jobs_done !== 32'd3) begin n_bad++; $display("FAIL pp_jobs_done: got %0d expected 3", jobs_done); end
    tick();
    core_out_TDATA  = 32'hB4;
    core_out_TVALID = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (rsp_TVALID !== 4'b0001) begin n_bad++; $display("FAIL pp_rsp_d: got %b expected 0001", rsp_TVALID); end
    tick();
    core_out_TVALID = 1'b0;
    req_TVALID      = '0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_fifo_full();
    test_gapped();
    test_orphan_and_reset();
    test_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
